// File: rtl/lcd_pkg.sv
// Shared types, LCD command bytes and character helpers for the LCD controller.
// Consumed by module_lcd_ctrl (optional LCD_HEX_EN build uses hexChar).
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        CONVERT,
        LINE1,
        LINE2
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EN,
        PH_WAIT
    } wr_phase_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;

    // Mnemonics are stored right-aligned with their length, then read left-justified.
    function automatic logic [7:0] mnemonicChar(input logic [2:0] op, input logic [3:0] pos);
        logic [55:0] text;
        logic [3:0]  len;
        logic [7:0]  ch;
        case (op)
            3'd0:    begin text = 56'("LOAD");    len = 4'd4; end
            3'd1:    begin text = 56'("ADD");     len = 4'd3; end
            3'd2:    begin text = 56'("ADDI");    len = 4'd4; end
            3'd3:    begin text = 56'("SUB");     len = 4'd3; end
            3'd4:    begin text = 56'("SUBI");    len = 4'd4; end
            3'd5:    begin text = 56'("MUL");     len = 4'd3; end
            3'd6:    begin text = 56'("CLEAR");   len = 4'd5; end
            default: begin text = 56'("DISPLAY"); len = 4'd7; end
        endcase
        ch = ASCII_SPACE;
        if (pos < len) begin
            ch = text[8 * (int'(len) - 1 - int'(pos)) +: 8];
        end
        return ch;
    endfunction

    function automatic logic [7:0] hexChar(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = ASCII_ZERO + {4'd0, nib};
        end else begin
            ch = 8'h41 + {4'd0, nib - 4'd10};
        end
        return ch;
    endfunction

endpackage

// File: rtl/module_lcd_ctrl_if.sv
// CPU-side capture inputs and HD44780 write bus for module_lcd_ctrl.
interface module_lcd_ctrl_if;

    logic        show;
    logic [2:0]  opcode;
    logic [15:0] result;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        busy;

    modport master (
        output show, opcode, result,
        input  lcd_data, lcd_rs, lcd_rw, lcd_en, busy
    );

    modport slave (
        input  show, opcode, result,
        output lcd_data, lcd_rs, lcd_rw, lcd_en, busy
    );

endinterface

// File: rtl/module_lcd_ctrl_bin2bcd.sv
// Sequential double-dabble: 17-bit magnitude to 5 BCD digits, one shift per cycle.
module module_bin2bcd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [16:0] bin_i,
    output logic [19:0] bcd_o,
    output logic        done_o
);

    logic [16:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [19:0] adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Each digit >= 5 gets +3 before the shift so it carries correctly into the next digit.
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        adj    = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = 5'd17;
        end else if (cnt_q != 5'd0) begin
            bcd_d  = {adj[18:0], bin_q[16]};
            bin_d  = {bin_q[15:0], 1'b0};
            cnt_d  = cnt_q - 5'd1;
            done_d = (cnt_q == 5'd1);
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = done_q;

endmodule

// File: rtl/module_lcd_ctrl.sv
// HD44780 16x2 controller: power-on init, then mnemonic on line 1 and result on line 2.
// Define LCD_HEX_EN to show line 2 as "0xHHHH" instead of signed decimal.
module module_lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int WAIT_INIT = 1000000,
    parameter int WAIT_CMD  = 2500,
    parameter int WAIT_CLR  = 100000,
    parameter int EN_HIGH   = 12
) (
    input logic              clk,
    input logic              rst_n,
    module_lcd_ctrl_if.slave bus
);

    localparam int MAXW1 = (WAIT_INIT > WAIT_CLR) ? WAIT_INIT : WAIT_CLR;
    localparam int MAXW2 = (WAIT_CMD > EN_HIGH) ? WAIT_CMD : EN_HIGH;
    localparam int MAXW  = (MAXW1 > MAXW2) ? MAXW1 : MAXW2;
    localparam int CW    = $clog2(MAXW + 1);

    lcd_state_t  state_q, state_d;
    wr_phase_t   phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d, en_q, en_d;
    logic        pending_q, pending_d;
    logic [2:0]  pendOp_q, pendOp_d, capOp_q, capOp_d;
    logic [15:0] pendRes_q, pendRes_d, capRes_q, capRes_d;

    logic [7:0]    curByte;
    logic          curRs;
    logic [3:0]    pos;
    logic [7:0]    line2Char;
    logic [4:0]    lastIdx;
    logic [CW-1:0] waitLast;
    logic          convDone;

`ifdef LCD_HEX_EN
    assign convDone = 1'b1;

    always_comb begin
        case (pos)
            4'd0:    line2Char = ASCII_ZERO;
            4'd1:    line2Char = 8'h78;
            4'd2:    line2Char = hexChar(capRes_q[15:12]);
            4'd3:    line2Char = hexChar(capRes_q[11:8]);
            4'd4:    line2Char = hexChar(capRes_q[7:4]);
            4'd5:    line2Char = hexChar(capRes_q[3:0]);
            default: line2Char = ASCII_SPACE;
        endcase
    end
`else
    logic        convStart;
    logic [15:0] selRes;
    logic [16:0] selExt, mag;
    logic [19:0] bcd;

    // 17-bit negate so that 0x8000 yields a magnitude of 32768 rather than wrapping.
    assign selRes    = bus.show ? bus.result : pendRes_q;
    assign selExt    = {selRes[15], selRes};
    assign mag       = selRes[15] ? (~selExt + 17'd1) : selExt;
    assign convStart = (state_q == IDLE) && (bus.show || pending_q);

    module_bin2bcd u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (convStart),
        .bin_i   (mag),
        .bcd_o   (bcd),
        .done_o  (convDone)
    );

    always_comb begin
        case (pos)
            4'd0:    line2Char = capRes_q[15] ? ASCII_MINUS : ASCII_SPACE;
            4'd1:    line2Char = ASCII_ZERO + {4'd0, bcd[19:16]};
            4'd2:    line2Char = ASCII_ZERO + {4'd0, bcd[15:12]};
            4'd3:    line2Char = ASCII_ZERO + {4'd0, bcd[11:8]};
            4'd4:    line2Char = ASCII_ZERO + {4'd0, bcd[7:4]};
            4'd5:    line2Char = ASCII_ZERO + {4'd0, bcd[3:0]};
            default: line2Char = ASCII_SPACE;
        endcase
    end
`endif

    assign pos      = idx_q[3:0] - 4'd1;
    assign lastIdx  = (state_q == INIT) ? 5'd3 : 5'd16;
    assign waitLast = (!rs_q && data_q == CMD_CLEAR) ? CW'(WAIT_CLR - 1) : CW'(WAIT_CMD - 1);

    always_comb begin
        curByte = ASCII_SPACE;
        curRs   = 1'b0;
        case (state_q)
            INIT: begin
                case (idx_q)
                    5'd0:    curByte = CMD_FUNC_SET;
                    5'd1:    curByte = CMD_DISP_ON;
                    5'd2:    curByte = CMD_ENTRY;
                    default: curByte = CMD_CLEAR;
                endcase
            end
            LINE1: begin
                curByte = (idx_q == 5'd0) ? CMD_LINE1 : mnemonicChar(capOp_q, pos);
                curRs   = (idx_q != 5'd0);
            end
            LINE2: begin
                curByte = (idx_q == 5'd0) ? CMD_LINE2 : line2Char;
                curRs   = (idx_q != 5'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PWR_WAIT;
            phase_q   <= PH_SETUP;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            rs_q      <= 1'b0;
            en_q      <= 1'b0;
            pending_q <= 1'b0;
            pendOp_q  <= '0;
            pendRes_q <= '0;
            capOp_q   <= '0;
            capRes_q  <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
            en_q      <= en_d;
            pending_q <= pending_d;
            pendOp_q  <= pendOp_d;
            pendRes_q <= pendRes_d;
            capOp_q   <= capOp_d;
            capRes_q  <= capRes_d;
        end
    end

    // Byte writes: SETUP latches rs/data, EN holds the strobe EN_HIGH cycles, WAIT lets the LCD settle.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        rs_d      = rs_q;
        en_d      = en_q;
        pending_d = pending_q;
        pendOp_d  = pendOp_q;
        pendRes_d = pendRes_q;
        capOp_d   = capOp_q;
        capRes_d  = capRes_q;

        if (bus.show && state_q != IDLE) begin
            pending_d = 1'b1;
            pendOp_d  = bus.opcode;
            pendRes_d = bus.result;
        end

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == CW'(WAIT_INIT - 1)) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    phase_d = PH_SETUP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                if (bus.show || pending_q) begin
                    capOp_d   = bus.show ? bus.opcode : pendOp_q;
                    capRes_d  = bus.show ? bus.result : pendRes_q;
                    pending_d = 1'b0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                if (convDone) begin
                    state_d = LINE1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    phase_d = PH_SETUP;
                end
            end
            INIT, LINE1, LINE2: begin
                case (phase_q)
                    PH_SETUP: begin
                        data_d  = curByte;
                        rs_d    = curRs;
                        cnt_d   = '0;
                        phase_d = PH_EN;
                    end
                    PH_EN: begin
                        if (cnt_q == CW'(EN_HIGH)) begin
                            en_d    = 1'b0;
                            cnt_d   = '0;
                            phase_d = PH_WAIT;
                        end else begin
                            en_d  = 1'b1;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == waitLast) begin
                            cnt_d   = '0;
                            phase_d = PH_SETUP;
                            if (idx_q == lastIdx) begin
                                idx_d   = '0;
                                state_d = (state_q == LINE1) ? LINE2 : IDLE;
                            end else begin
                                idx_d = idx_q + 5'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                endcase
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    assign bus.lcd_data = data_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_en   = en_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_module_lcd_ctrl.sv
// Directed self-checking bench for module_lcd_ctrl with shortened LCD timings.
// Build with LCD_HEX_EN defined to check the hexadecimal line-2 variant.
module tb_module_lcd_ctrl;

    logic clk;
    logic rst_n;
    int   assertCount = 0;
    int   failCount   = 0;
    int   cycleCnt    = 0;
    int   riseCycle   = -1;
    logic prevEn      = 1'b0;
    logic [8:0] heldByte = '0;
    logic [8:0] capQ[$];

    module_lcd_ctrl_if bus ();

    module_lcd_ctrl #(
        .WAIT_INIT (20),
        .WAIT_CMD  (4),
        .WAIT_CLR  (8),
        .EN_HIGH   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Every rising strobe logs {rs,data}; the bus must not move before the strobe falls.
    always @(negedge clk) begin
        cycleCnt++;
        if (bus.lcd_en && !prevEn) begin
            capQ.push_back({bus.lcd_rs, bus.lcd_data});
            heldByte = {bus.lcd_rs, bus.lcd_data};
            if (riseCycle < 0) riseCycle = cycleCnt;
        end
        if (!bus.lcd_en && prevEn && rst_n) begin
            checkOutput("hold through en fall", {119'd0, bus.lcd_rs, bus.lcd_data}, {119'd0, heldByte});
        end
        prevEn = bus.lcd_en;
    end

    function automatic logic [127:0] pad16(input string s);
        logic [127:0] v;
        v = {16{8'h20}};
        for (int i = 0; i < s.len() && i < 16; i++) begin
            v[127 - 8*i -: 8] = s[i];
        end
        return v;
    endfunction

    function automatic logic [127:0] l2(input string decText, input string hexText);
`ifdef LCD_HEX_EN
        return pad16(hexText);
`else
        return pad16(decText);
`endif
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] res);
        @(posedge clk);
        #1;
        bus.show   = 1'b1;
        bus.opcode = op;
        bus.result = res;
        @(posedge clk);
        #1;
        bus.show = 1'b0;
    endtask

    task automatic waitBytes(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (capQ.size() >= n) break;
        end
        checkOutput("byte count reached", {127'd0, capQ.size() >= n}, 128'd1);
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        checkOutput("busy low", {127'd0, bus.busy}, 128'd0);
    endtask

    task automatic checkLine(input string tag, input logic [8:0] cmd, input logic [127:0] text);
        logic [127:0] got;
        logic         rsAll;
        logic [8:0]   b;
        got   = '0;
        rsAll = 1'b1;
        b     = capQ.pop_front();
        checkOutput({tag, " cmd"}, {119'd0, b}, {119'd0, cmd});
        for (int i = 0; i < 16; i++) begin
            b = capQ.pop_front();
            got[127 - 8*i -: 8] = b[7:0];
            rsAll = rsAll & b[8];
        end
        checkOutput({tag, " text"}, got, text);
        checkOutput({tag, " rs"}, {127'd0, rsAll}, 128'd1);
    endtask

    task automatic checkRefresh(input string mnem, input logic [127:0] line2);
        waitBytes(34, 3000);
        if (capQ.size() >= 34) begin
            checkLine("line1", 9'h080, pad16(mnem));
            checkLine("line2", 9'h0C0, line2);
        end
        waitIdle(500);
    endtask

    task automatic checkInit();
        logic [8:0] b;
        logic [8:0] exp [4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
        waitBytes(4, 1000);
        for (int i = 0; i < 4; i++) begin
            if (capQ.size() > 0) begin
                b = capQ.pop_front();
                checkOutput($sformatf("init byte %0d", i), {119'd0, b}, {119'd0, exp[i]});
            end
        end
        waitIdle(500);
    endtask

    initial begin
        int relCycle;
        rst_n      = 1'b0;
        bus.show   = 1'b0;
        bus.opcode = '0;
        bus.result = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset lcd_data", {120'd0, bus.lcd_data}, 128'd0);
        checkOutput("reset lcd_rs", {127'd0, bus.lcd_rs}, 128'd0);
        checkOutput("reset lcd_rw", {127'd0, bus.lcd_rw}, 128'd0);
        checkOutput("reset lcd_en", {127'd0, bus.lcd_en}, 128'd0);
        checkOutput("reset busy", {127'd0, bus.busy}, 128'd1);

        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        relCycle = cycleCnt;
        checkInit();
        checkOutput("power-on wait length", {127'd0, (riseCycle - relCycle >= 20) && (riseCycle - relCycle <= 26)}, 128'd1);

        applyStimulus(3'd1, 16'd42);
        checkRefresh("ADD", l2(" 00042", "0x002A"));
        applyStimulus(3'd3, 16'hFFFF);
        checkRefresh("SUB", l2("-00001", "0xFFFF"));
        applyStimulus(3'd5, 16'h8000);
        checkRefresh("MUL", l2("-32768", "0x8000"));
        applyStimulus(3'd0, 16'h7FFF);
        checkRefresh("LOAD", l2(" 32767", "0x7FFF"));
        applyStimulus(3'd1, 16'hBEEF);
        checkRefresh("ADD", l2("-16657", "0xBEEF"));

        $display("[TB] two pulses during a refresh, last one wins");
        applyStimulus(3'd7, 16'd100);
        repeat (50) @(posedge clk);
        applyStimulus(3'd6, 16'd5);
        repeat (20) @(posedge clk);
        applyStimulus(3'd4, 16'd7);
        checkRefresh("DISPLAY", l2(" 00100", "0x0064"));
        checkRefresh("SUBI", l2(" 00007", "0x0007"));
        repeat (400) @(negedge clk);
        checkOutput("no extra refresh", {96'd0, 32'(capQ.size())}, 128'd0);

        $display("[TB] reset while strobing mid line 1");
        applyStimulus(3'd2, 16'd1);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (capQ.size() >= 3 && bus.lcd_en) break;
        end
        checkOutput("en high before reset", {127'd0, bus.lcd_en}, 128'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("en drops on reset", {127'd0, bus.lcd_en}, 128'd0);
        checkOutput("busy on reset", {127'd0, bus.busy}, 128'd1);
        repeat (2) @(negedge clk);
        capQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkInit();
        repeat (400) @(negedge clk);
        checkOutput("no refresh after reset", {96'd0, 32'(capQ.size())}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
